// File: rtl/w_wb_arbiter_pkg.sv
// Shared pipeline definitions for the write-back path.
// It holds the register index width, the hard-wired zero register and the write request record.
package w_wb_arbiter_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

    // Data field width of a write request; the arbiter's DW must not exceed it.
    localparam int XLEN = 32;

    typedef struct packed {
        logic [REG_W-1:0] a3;
        logic [XLEN-1:0]  wd;
        logic [31:0]      pc;
    } wb_req_t;

endpackage

// File: rtl/w_wb_arbiter_fifo.sv
// Synchronous FIFO of write requests with wrapping head/tail pointers.
// It exposes per-slot valid and address so pending writes can be looked up without popping.
module wb_fifo
    import w_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  wb_req_t                     push_req,
    input  logic                        pop,
    output wb_req_t                     head_req,
    output logic                        full,
    output logic [$clog2(DEPTH):0]      count,
    output logic [DEPTH-1:0]            entry_vld,
    output logic [DEPTH-1:0][REG_W-1:0] entry_a3
);

    localparam int PW = $clog2(DEPTH);

    wb_req_t       mem [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (PW+1)'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && (count != '0);
    assign head_req = mem[head_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push)
                tail_ptr <= tail_ptr + PW'(1);
            if (do_pop)
                head_ptr <= head_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[tail_ptr] <= push_req;
    end

    // A slot is live when its distance from the head, modulo DEPTH, is below the occupancy.
    always_comb begin
        entry_vld = '0;
        entry_a3  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_vld[i] = ({1'b0, PW'(PW'(i) - head_ptr)} < count);
            entry_a3[i]  = mem[i].a3;
        end
    end

endmodule

// File: rtl/w_wb_arbiter.sv
// Write-back arbiter: W-stage writes always win the register-file port, buffered MDU results fill idle slots.
// Define WB_TRACE_EN to print a commit trace line for every register-file write.
module w_wb_arbiter
    import w_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pipe_we,
    input  logic [4:0]             pipe_a3,
    input  logic [DW-1:0]          pipe_wd,
    input  logic [31:0]            pipe_pc,
    input  logic                   mdu_valid,
    output logic                   mdu_ready,
    input  logic [4:0]             mdu_a3,
    input  logic [DW-1:0]          mdu_wd,
    input  logic [31:0]            mdu_pc,
    input  logic [4:0]             q_a1,
    input  logic [4:0]             q_a2,
    output logic                   q_hit1,
    output logic                   q_hit2,
    output logic                   pipe_hold,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   rf_we,
    output logic [4:0]             rf_a3,
    output logic [DW-1:0]          rf_wd,
    output logic [31:0]            rf_wpc
);

    wb_req_t                     pipe_req_p0;
    wb_req_t                     mdu_req_p0;
    wb_req_t                     head_req_p0;
    logic                        eff_pipe_p0;
    logic                        push_p0;
    logic                        pop_p0;
    logic                        full_p0;
    logic [DEPTH-1:0]            entry_vld_p0;
    logic [DEPTH-1:0][REG_W-1:0] entry_a3_p0;

    // ---- stage p0: request qualification and FIFO ----
    assign pipe_req_p0 = '{a3: pipe_a3, wd: XLEN'(pipe_wd), pc: pipe_pc};
    assign mdu_req_p0  = '{a3: mdu_a3,  wd: XLEN'(mdu_wd),  pc: mdu_pc};

    assign eff_pipe_p0 = pipe_we && (pipe_a3 != ZERO_REG);
    assign mdu_ready   = !reset && !full_p0;
    // Results for $0 are handshaken but never stored.
    assign push_p0     = mdu_valid && mdu_ready && (mdu_a3 != ZERO_REG);
    assign pop_p0      = !eff_pipe_p0 && (fifo_count != '0);
    assign pipe_hold   = full_p0;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_p0),
        .push_req  (mdu_req_p0),
        .pop       (pop_p0),
        .head_req  (head_req_p0),
        .full      (full_p0),
        .count     (fifo_count),
        .entry_vld (entry_vld_p0),
        .entry_a3  (entry_a3_p0)
    );

    always_comb begin
        q_hit1 = 1'b0;
        q_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld_p0[i] && (q_a1 != ZERO_REG) && (entry_a3_p0[i] == q_a1))
                q_hit1 = 1'b1;
            if (entry_vld_p0[i] && (q_a2 != ZERO_REG) && (entry_a3_p0[i] == q_a2))
                q_hit2 = 1'b1;
        end
    end

    // ---- stage p1: register-file write register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we  <= 1'b0;
            rf_a3  <= '0;
            rf_wd  <= '0;
            rf_wpc <= '0;
        end else if (eff_pipe_p0) begin
            rf_we  <= 1'b1;
            rf_a3  <= pipe_req_p0.a3;
            rf_wd  <= DW'(pipe_req_p0.wd);
            rf_wpc <= pipe_req_p0.pc;
        end else if (pop_p0) begin
            rf_we  <= 1'b1;
            rf_a3  <= head_req_p0.a3;
            rf_wd  <= DW'(head_req_p0.wd);
            rf_wpc <= head_req_p0.pc;
        end else begin
            rf_we  <= 1'b0;
        end
    end

`ifdef WB_TRACE_EN
    always @(posedge clk) begin
        if (!reset && rf_we)
            $display("%d@%h: $%d <= %h", $time, rf_wpc, rf_a3, rf_wd);
    end
`else
`endif

endmodule

// File: tb/tb_w_wb_arbiter.sv
// Self-checking bench for w_wb_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model of the write-back port.
module tb_w_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_a3;
    logic [31:0] pipe_wd;
    logic [31:0] pipe_pc;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_a3;
    logic [31:0] mdu_wd;
    logic [31:0] mdu_pc;
    logic [4:0]  q_a1;
    logic [4:0]  q_a2;
    logic        q_hit1;
    logic        q_hit2;
    logic        pipe_hold;
    logic [2:0]  fifo_count;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic [31:0] rf_wpc;

    w_wb_arbiter #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .pipe_we    (pipe_we),
        .pipe_a3    (pipe_a3),
        .pipe_wd    (pipe_wd),
        .pipe_pc    (pipe_pc),
        .mdu_valid  (mdu_valid),
        .mdu_ready  (mdu_ready),
        .mdu_a3     (mdu_a3),
        .mdu_wd     (mdu_wd),
        .mdu_pc     (mdu_pc),
        .q_a1       (q_a1),
        .q_a2       (q_a2),
        .q_hit1     (q_hit1),
        .q_hit2     (q_hit2),
        .pipe_hold  (pipe_hold),
        .fifo_count (fifo_count),
        .rf_we      (rf_we),
        .rf_a3      (rf_a3),
        .rf_wd      (rf_wd),
        .rf_wpc     (rf_wpc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic        exp_we  = 1'b0;
    logic [4:0]  exp_a3  = '0;
    logic [31:0] exp_wd  = '0;
    logic [31:0] exp_wpc = '0;
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic logic m_hit(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].a3 == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle_inputs();
        pipe_we = 0; pipe_a3 = 0; pipe_wd = 0; pipe_pc = 0;
        mdu_valid = 0; mdu_a3 = 0; mdu_wd = 0; mdu_pc = 0;
        q_a1 = 0; q_a2 = 0;
    endtask

    // One clock: the reference model consumes the inputs seen at the edge.
    task automatic step();
        ent_t e;
        bit   acc;
        acc = !reset && mdu_valid && (mq.size() < DEPTH);
        @(posedge clk);
        if (reset) begin
            mq.delete();
            exp_we = 0; exp_a3 = 0; exp_wd = 0; exp_wpc = 0;
        end else begin
            if (pipe_we && pipe_a3 != 5'd0) begin
                exp_we = 1; exp_a3 = pipe_a3; exp_wd = pipe_wd; exp_wpc = pipe_pc;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                exp_we = 1; exp_a3 = e.a3; exp_wd = e.wd; exp_wpc = e.pc;
            end else begin
                exp_we = 0;
            end
            if (acc && mdu_a3 != 5'd0) begin
                e.a3 = mdu_a3; e.wd = mdu_wd; e.pc = mdu_pc;
                mq.push_back(e);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs(); q_a1 = 5;
        step(); step();
        n_tests++; if ({rf_we, rf_a3, rf_wd, rf_wpc} !== '0) begin n_fail++;
            $display("FAIL reset_rf got we=%0d a3=%0d wd=%h pc=%h want all 0", rf_we, rf_a3, rf_wd, rf_wpc); end
        n_tests++; if (fifo_count !== 3'd0 || pipe_hold !== 1'b0) begin n_fail++;
            $display("FAIL reset_fifo got count=%0d hold=%0d want 0/0", fifo_count, pipe_hold); end
        n_tests++; if (q_hit1 !== 1'b0 || q_hit2 !== 1'b0) begin n_fail++;
            $display("FAIL reset_qhit got %0d/%0d want 0/0", q_hit1, q_hit2); end
        n_tests++; if (mdu_ready !== 1'b0) begin n_fail++;
            $display("FAIL reset_ready_hi got %0d want 0", mdu_ready); end
        reset = 0; #1;
        n_tests++; if (mdu_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_ready_lo got %0d want 1", mdu_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++; if (rf_we !== 1'b0) begin n_fail++;
                $display("FAIL idle_we cycle %0d got %0d want 0", i, rf_we); end
        end
    endtask

    task automatic test_pipe_write();
        pipe_we = 1; pipe_a3 = 8; pipe_wd = 32'h12345678; pipe_pc = 32'h3000;
        step();
        idle_inputs();
        n_tests++; if ({rf_we, rf_a3, rf_wd, rf_wpc} !== {1'b1, 5'd8, 32'h12345678, 32'h3000}) begin n_fail++;
            $display("FAIL pipe_write got we=%0d a3=%0d wd=%h pc=%h want 1/8/12345678/00003000", rf_we, rf_a3, rf_wd, rf_wpc); end
        step();
        n_tests++; if (rf_we !== 1'b0 || rf_a3 !== 5'd8 || rf_wd !== 32'h12345678) begin n_fail++;
            $display("FAIL pipe_hold_value got we=%0d a3=%0d wd=%h want 0/8/12345678", rf_we, rf_a3, rf_wd); end
    endtask

    task automatic test_mdu_queued();
        pipe_we = 1; pipe_a3 = 11; pipe_wd = 32'h111; pipe_pc = 32'h100;
        mdu_valid = 1; mdu_a3 = 3; mdu_wd = 32'hA; mdu_pc = 32'h4000;
        q_a1 = 3;
        step();
        mdu_valid = 0;
        n_tests++; if (fifo_count !== 3'd1 || q_hit1 !== 1'b1) begin n_fail++;
            $display("FAIL mdu_enq got count=%0d hit=%0d want 1/1", fifo_count, q_hit1); end
        n_tests++; if (rf_a3 !== 5'd11) begin n_fail++;
            $display("FAIL mdu_pipe_wins got a3=%0d want 11", rf_a3); end
        for (int i = 0; i < 2; i++) begin
            pipe_a3 = 5'(12 + i);
            step();
        end
        n_tests++; if (q_hit1 !== 1'b1 || rf_a3 !== 5'd13 || fifo_count !== 3'd1) begin n_fail++;
            $display("FAIL mdu_starved got hit=%0d a3=%0d count=%0d want 1/13/1", q_hit1, rf_a3, fifo_count); end
        pipe_we = 0;
        step();
        n_tests++; if ({rf_we, rf_a3, rf_wd, rf_wpc} !== {1'b1, 5'd3, 32'hA, 32'h4000}) begin n_fail++;
            $display("FAIL mdu_drain got we=%0d a3=%0d wd=%h pc=%h want 1/3/0000000a/00004000", rf_we, rf_a3, rf_wd, rf_wpc); end
        n_tests++; if (q_hit1 !== 1'b0 || fifo_count !== 3'd0) begin n_fail++;
            $display("FAIL mdu_after got hit=%0d count=%0d want 0/0", q_hit1, fifo_count); end
        idle_inputs();
    endtask

    task automatic test_fill_drain();
        pipe_we = 1; pipe_wd = 32'hBEEF; pipe_pc = 32'h200;
        for (int k = 1; k <= 4; k++) begin
            pipe_a3 = 5'(8 + k);
            mdu_valid = 1; mdu_a3 = 5'(k); mdu_wd = 32'(k * 32'h11); mdu_pc = 32'(32'h5000 + 4 * k);
            step();
        end
        n_tests++; if (fifo_count !== 3'd4 || pipe_hold !== 1'b1 || mdu_ready !== 1'b0) begin n_fail++;
            $display("FAIL fill got count=%0d hold=%0d ready=%0d want 4/1/0", fifo_count, pipe_hold, mdu_ready); end
        mdu_a3 = 5; pipe_a3 = 20;
        step();
        n_tests++; if (fifo_count !== 3'd4 || rf_a3 !== 5'd20) begin n_fail++;
            $display("FAIL full_no_pass got count=%0d a3=%0d want 4/20", fifo_count, rf_a3); end
        mdu_valid = 0; pipe_we = 0;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_tests++; if (rf_we !== 1'b1 || rf_a3 !== 5'(k) || rf_wd !== 32'(k * 32'h11)) begin n_fail++;
                $display("FAIL drain_order slot %0d got we=%0d a3=%0d wd=%h want 1/%0d", k, rf_we, rf_a3, rf_wd, k); end
        end
        n_tests++; if (fifo_count !== 3'd0 || mdu_ready !== 1'b1 || pipe_hold !== 1'b0) begin n_fail++;
            $display("FAIL drained got count=%0d ready=%0d hold=%0d want 0/1/0", fifo_count, mdu_ready, pipe_hold); end
        idle_inputs();
    endtask

    task automatic test_zero_reg();
        pipe_we = 1; pipe_a3 = 0; pipe_wd = 32'hDEAD; pipe_pc = 32'h600;
        mdu_valid = 1; mdu_a3 = 0; mdu_wd = 32'hF00D; mdu_pc = 32'h700;
        q_a1 = 0;
        step();
        n_tests++; if (rf_we !== 1'b0 || rf_a3 !== 5'd4) begin n_fail++;
            $display("FAIL zero_write got we=%0d a3=%0d want 0/4", rf_we, rf_a3); end
        n_tests++; if (fifo_count !== 3'd0 || q_hit1 !== 1'b0) begin n_fail++;
            $display("FAIL zero_enq got count=%0d hit=%0d want 0/0", fifo_count, q_hit1); end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_midflight();
        pipe_we = 1; pipe_a3 = 30; pipe_wd = 32'h1; pipe_pc = 32'h800;
        for (int k = 0; k < 3; k++) begin
            mdu_valid = 1; mdu_a3 = 5'(20 + k); mdu_wd = 32'(k); mdu_pc = 32'h900;
            step();
        end
        mdu_valid = 0; q_a1 = 21; q_a2 = 22; #1;
        n_tests++; if (fifo_count !== 3'd3 || q_hit1 !== 1'b1 || q_hit2 !== 1'b1) begin n_fail++;
            $display("FAIL pre_reset got count=%0d hits=%0d/%0d want 3/1/1", fifo_count, q_hit1, q_hit2); end
        reset = 1; pipe_we = 0;
        step();
        n_tests++; if (fifo_count !== 3'd0 || rf_we !== 1'b0 || q_hit1 !== 1'b0 || q_hit2 !== 1'b0) begin n_fail++;
            $display("FAIL mid_reset got count=%0d we=%0d hits=%0d/%0d want 0/0/0/0", fifo_count, rf_we, q_hit1, q_hit2); end
        reset = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_tests++; if (rf_we !== 1'b0) begin n_fail++;
                $display("FAIL lost_entries cycle %0d got we=%0d a3=%0d want we=0", i, rf_we, rf_a3); end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(0, 99) == 0);
            pipe_we   = (mq.size() == DEPTH) ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
            pipe_a3   = 5'($urandom_range(0, 7));
            pipe_wd   = $urandom;
            pipe_pc   = $urandom;
            mdu_valid = 1'($urandom_range(0, 1));
            mdu_a3    = 5'($urandom_range(0, 7));
            mdu_wd    = $urandom;
            mdu_pc    = $urandom;
            q_a1      = 5'($urandom_range(0, 7));
            q_a2      = 5'($urandom_range(0, 7));
            #1;
            n_tests++; if (mdu_ready !== (!reset && mq.size() < DEPTH)) begin n_fail++;
                $display("FAIL rand_ready cycle %0d got %0d want %0d", c, mdu_ready, (!reset && mq.size() < DEPTH)); end
            n_tests++; if (q_hit1 !== m_hit(q_a1) || q_hit2 !== m_hit(q_a2)) begin n_fail++;
                $display("FAIL rand_qhit cycle %0d got %0d/%0d want %0d/%0d", c, q_hit1, q_hit2, m_hit(q_a1), m_hit(q_a2)); end
            step();
            n_tests++; if ({rf_we, rf_a3, rf_wd, rf_wpc} !== {exp_we, exp_a3, exp_wd, exp_wpc}) begin n_fail++;
                $display("FAIL rand_rf cycle %0d got we=%0d a3=%0d wd=%h pc=%h want we=%0d a3=%0d wd=%h pc=%h",
                         c, rf_we, rf_a3, rf_wd, rf_wpc, exp_we, exp_a3, exp_wd, exp_wpc); end
            n_tests++; if (fifo_count !== 3'(mq.size()) || pipe_hold !== (mq.size() == DEPTH)) begin n_fail++;
                $display("FAIL rand_count cycle %0d got count=%0d hold=%0d want %0d", c, fifo_count, pipe_hold, mq.size()); end
        end
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_pipe_write();
        test_mdu_queued();
        test_fill_drain();
        test_zero_reg();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/w_wb_arbiter.md
# w_wb_arbiter

Write-back arbiter that owns the single register-file write port of the five-stage pipeline. It merges two producers into one registered write stream of address, data, write-enable and PC. The first is the in-order W-stage result, which always wins. The second is the long-latency multiply/divide result, buffered in a small FIFO and drained into idle write slots. It also reports which registers still have buffered, uncommitted writes, so the D-stage stall logic can hold dependent readers.

## Interface
Parameters:
- DEPTH, 4, MDU result FIFO entries (power of two, ≥2)
- DW, 32, data width

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  synchronous, active-high
- pipe_we  in  1  W-stage write request
- pipe_a3  in  5  W-stage destination register
- pipe_wd  in  DW  W-stage write data
- pipe_pc  in  32  W-stage instruction PC
- mdu_valid  in  1  MDU result offered
- mdu_ready  out  1  FIFO accepts MDU result
- mdu_a3  in  5  MDU destination register
- mdu_wd  in  DW  MDU result data
- mdu_pc  in  32  PC of originating MDU instruction
- q_a1, q_a2  in  5 each  D-stage source registers to check
- q_hit1, q_hit2  out  1 each  the matching q_a has a buffered pending write
- pipe_hold  out  1  FIFO full; the pipeline must present no write next cycle
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy
- rf_we  out  1  register-file write enable
- rf_a3  out  5  register-file write address
- rf_wd  out  DW  register-file write data
- rf_wpc  out  32  PC of committed write

## Operation
- Effective pipe write: pipe_we==1 and pipe_a3!=0. Writes targeting $0 from either source are discarded and never appear on rf_*.
- MDU results with mdu_a3==0 are accepted and dropped; they are not enqueued.
- Enqueue: on a rising edge with mdu_valid && mdu_ready and mdu_a3!=0.
- mdu_ready = !reset && fifo_count<DEPTH. There is no pass-through when full, even if a dequeue happens in the same cycle.
- Each cycle the rf_* register loads exactly one of the following, in priority order:
  1. an effective pipe write;
  2. else, if fifo_count>0, the FIFO head (dequeued on the same edge);
  3. else rf_we=0, with rf_a3, rf_wd and rf_wpc holding their previous values.
- Simultaneous enqueue and dequeue: count is unchanged, and entry ordering is preserved (strict FIFO).
- The FIFO uses head/tail pointers that wrap modulo DEPTH.
- pipe_hold = (fifo_count==DEPTH). While it is high, the upstream pipeline inserts a bubble so the head can drain, which bounds MDU starvation to one bubble.
- An effective pipe write while pipe_hold is high is still honoured. The FIFO then waits; this is a protocol violation upstream but must not corrupt state.
- q_hitN = 1 iff q_aN!=0 and any valid FIFO entry has a3==q_aN. This is combinational.
- The entry currently in the rf_* register is not reported by q_hit. The register file's write-through bypass covers it.

## Timing
- Pipe write presented in cycle N appears on rf_* in cycle N+1 and commits at the end of N+1.
- MDU result accepted at the edge ending cycle N reaches rf_* at the earliest in cycle N+2.
- fifo_count and q_hit reflect an enqueue from the cycle after the accepting edge.
- Reset (any cycle, including mid-drain) clears the FIFO. The buffered entries are lost, and the MDU is reset by the same signal.
- Reset values: rf_we=0, rf_a3=0, rf_wd=0, rf_wpc=0, fifo_count=0, pipe_hold=0, q_hit1=q_hit2=0, mdu_ready=0 while reset is high and 1 on the first cycle after.

## Configuration
- WB_TRACE_EN defined: on every rising edge where the outgoing write commits (rf_we==1 and not reset), print one line via $display in the form "%d@%h: $%d <= %h" with $time, rf_wpc, rf_a3, rf_wd. This is the format of the grading trace.
- WB_TRACE_EN undefined: no display code and no behavioural difference.

## Structure
- Shared pipeline package holds: the register-index width constant (5), the ZERO_REG constant, and a wb_req_t struct {a3, wd, pc}. Both the inputs and the FIFO entries use wb_req_t.
- Sub-module wb_fifo: a parameterised synchronous FIFO of wb_req_t with push, pop, full, count and an entry-valid/address view for the q_hit compare. The arbiter is the top-level selection plus the output register.

## Test plan
- Reset then idle: all outputs 0, mdu_ready=1 after reset drops, and rf_we stays 0 with no inputs.
- Pipe write (a3=8, wd=0x12345678, pc=0x3000) in cycle N: rf_we=1, rf_a3=8, rf_wd=0x12345678 in N+1; the trace prints once if WB_TRACE_EN is defined.
- MDU result (a3=3, wd=0xA) while pipe writes every cycle: it stays queued and q_hit1=1 for q_a1=3. The first pipe bubble emits a3=3 on the next cycle, after which q_hit1=0.
- Fill DEPTH=4 MDU entries with a3=1..4 and continuous pipe writes: mdu_ready=0 and pipe_hold=1 at count 4. Bubbles drain entries in order 1,2,3,4.
- Writes to $0 from either source: never appear on rf_*, count is unchanged, and q_a1=0 gives q_hit1=0.
- Reset asserted with 3 entries queued: the next cycle shows count=0, rf_we=0, q_hit=0, and none of the queued entries are ever emitted.
